// File: rtl/dct_butterfly_stage.sv
// First DCT butterfly stage. Collects N samples and then registers the N/2 sums and N/2 differences.
// Latency: out_valid rises 2 edges after the last sample is accepted.
// Backpressure: in_ready is low outside FILL; a result frame is held until out_ready.
module dct_butterfly_stage #(
    parameter int N       = 32,
    parameter int WIDTH_X = 16,
    parameter int WIDTH_Y = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [WIDTH_X-1:0]       in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N/2*WIDTH_Y-1:0]   a_out,
    output logic [N/2*WIDTH_Y-1:0]   b_out,
    output logic [15:0]              frame_cnt
);

    localparam int IW = $clog2(N);
    localparam int H  = N / 2;

    typedef enum logic [1:0] {FILL, CALC, HOLD} state_t;

    state_t             state, state_nxt;
    logic [IW-1:0]      idx;
    logic [WIDTH_X-1:0] x [N];
    logic               accept, last, deliver;

    function automatic logic [WIDTH_Y-1:0] sext(input logic [WIDTH_X-1:0] v);
        return {{(WIDTH_Y-WIDTH_X){v[WIDTH_X-1]}}, v};
    endfunction

    assign in_ready  = (state == FILL);
    assign out_valid = (state == HOLD);
    // clr wins over any handshake in the same cycle
    assign accept  = in_valid && in_ready && !clr;
    assign last    = accept && (idx == IW'(N-1));
    assign deliver = out_valid && out_ready && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = FILL;
        end else begin
            case (state)
                FILL:    if (last) state_nxt = CALC;
                CALC:    state_nxt = HOLD;
                HOLD:    if (out_ready) state_nxt = FILL;
                default: state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      idx <= '0;
        else if (clr)    idx <= '0;
        else if (accept) idx <= last ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) x[i] <= '0;
        end else if (accept) begin
            x[idx] <= in_data;
        end
    end

    // Results stay on the outputs after handoff until the next frame is computed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
        end else if (state == CALC && !clr) begin
            for (int k = 0; k < H; k++) begin
                a_out[k*WIDTH_Y +: WIDTH_Y] <= sext(x[k]) + sext(x[N-1-k]);
                b_out[k*WIDTH_Y +: WIDTH_Y] <= sext(x[k]) - sext(x[N-1-k]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       frame_cnt <= '0;
        else if (deliver) frame_cnt <= frame_cnt + 16'd1;
    end

endmodule
